// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store sequencer and its lane aligner:
// decoder LControl/SControl encodings, byte-size masks, the sequencer state
// type and small decode helpers used by both the sequencer and any future
// cache path.
// ---------------------------------------------------------------------------
package lsu_pkg;

    // Load type encodings (LControl from the decoder)
    localparam logic [2:0] LCTRL_LB  = 3'b000;
    localparam logic [2:0] LCTRL_LH  = 3'b001;
    localparam logic [2:0] LCTRL_LW  = 3'b010;
    localparam logic [2:0] LCTRL_LBU = 3'b011;
    localparam logic [2:0] LCTRL_LHU = 3'b100;

    // Store type encodings (SControl from the decoder)
    localparam logic [1:0] SCTRL_SB  = 2'b00;
    localparam logic [1:0] SCTRL_SH  = 2'b01;
    localparam logic [1:0] SCTRL_SW  = 2'b10;

    // Byte-lane masks for an access starting at lane 0
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    // Size mask for an access; illegal encodings yield an empty mask so they
    // can never look like a crossing access.
    function automatic logic [3:0] size_mask(input logic       we,
                                             input logic [2:0] lctrl,
                                             input logic [1:0] sctrl);
        logic [3:0] mask;
        mask = MASK_NONE;
        if (we) begin
            case (sctrl)
                SCTRL_SB: mask = MASK_BYTE;
                SCTRL_SH: mask = MASK_HALF;
                SCTRL_SW: mask = MASK_WORD;
                default:  mask = MASK_NONE;
            endcase
        end else begin
            case (lctrl)
                LCTRL_LB, LCTRL_LBU: mask = MASK_BYTE;
                LCTRL_LH, LCTRL_LHU: mask = MASK_HALF;
                LCTRL_LW:            mask = MASK_WORD;
                default:             mask = MASK_NONE;
            endcase
        end
        return mask;
    endfunction

    // True when the encoding for the selected direction is not defined
    function automatic logic is_illegal(input logic       we,
                                        input logic [2:0] lctrl,
                                        input logic [1:0] sctrl);
        logic bad;
        if (we) begin
            bad = (sctrl == 2'b11);
        end else begin
            bad = (lctrl > LCTRL_LHU);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// ---------------------------------------------------------------------------
// lsu_sequencer_if
// Bundles the core-side request/response signals and the data-memory
// handshake of the load/store sequencer.
//   slave  : the sequencer's view (serves core requests, drives memory)
//   master : the environment's view (core issuing requests plus the memory
//            returning mem_ready/mem_rdata)
// ---------------------------------------------------------------------------
interface lsu_sequencer_if;
    // core request
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_lctrl;
    logic [1:0]  req_sctrl;
    // core response
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // data memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lctrl, req_sctrl,
        input  mem_ready, mem_rdata,
        output stall, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lctrl, req_sctrl,
        output mem_ready, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane aligner.
//   off, mask        : byte offset in the word and lane-0 size mask
//   wdata            : store data before lane shifting
//   lctrl            : load type used for extension
//   rd_lo, rd_hi     : read data of word0 and word1
//   be_lo, be_hi     : byte enables for word0 / word1
//   wdata_lo/hi      : lane-aligned store data for word0 / word1
//   crossing         : access touches word1
//   load_data        : extracted and extended load result
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    input  logic [2:0]  lctrl,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic        crossing,
    output logic [31:0] load_data
);

    logic [4:0]  shamt_s;
    logic [7:0]  be_wide_s;
    logic [63:0] wdata_wide_s;
    logic [31:0] load_raw_s;

    // Lane shifting of enables/store data and extraction of the loaded bytes
    always_comb begin
        shamt_s      = {off, 3'b000};
        be_wide_s    = {4'b0000, mask} << off;
        wdata_wide_s = {32'h0000_0000, wdata} << shamt_s;
        load_raw_s   = 32'({rd_hi, rd_lo} >> shamt_s);
        be_lo        = be_wide_s[3:0];
        be_hi        = be_wide_s[7:4];
        wdata_lo     = wdata_wide_s[31:0];
        wdata_hi     = wdata_wide_s[63:32];
        crossing     = (be_wide_s[7:4] != 4'b0000);
    end

    // Sign/zero extension of the extracted load data
    always_comb begin
        load_data = 32'h0000_0000;
        case (lctrl)
            LCTRL_LB:  load_data = {{24{load_raw_s[7]}}, load_raw_s[7:0]};
            LCTRL_LH:  load_data = {{16{load_raw_s[15]}}, load_raw_s[15:0]};
            LCTRL_LW:  load_data = load_raw_s;
            LCTRL_LBU: load_data = {24'h00_0000, load_raw_s[7:0]};
            LCTRL_LHU: load_data = {16'h0000, load_raw_s[15:0]};
            default:   load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_sequencer
// Multi-cycle load/store sequencer between the core and a variable-latency
// data memory. Word-crossing accesses are split into two word transactions
// (or rejected when SPLIT_EN=0); each transaction times out after
// TIMEOUT_CYCLES cycles without mem_ready.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   bus        : request/response and memory handshake (slave modport)
// ---------------------------------------------------------------------------
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit SPLIT_EN       = 1'b1
)
(
    input  logic          clk,
    input  logic          reset,
    lsu_sequencer_if.slave bus
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_t     state_r;
    lsu_state_t     state_next_s;
    logic           we_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic [2:0]     lctrl_r;
    logic [1:0]     sctrl_r;
    logic [31:0]    rd0_r;
    logic           err_r;
    logic [31:0]    rsp_rdata_r;
    logic [TW-1:0]  timer_r;

    // align inputs / outputs
    logic           a_we_s;
    logic [31:0]    a_addr_s;
    logic [31:0]    a_wdata_s;
    logic [2:0]     a_lctrl_s;
    logic [1:0]     a_sctrl_s;
    logic [31:0]    a_rd_lo_s;
    logic [31:0]    a_rd_hi_s;
    logic [3:0]     be_lo_s;
    logic [3:0]     be_hi_s;
    logic [31:0]    wdata_lo_s;
    logic [31:0]    wdata_hi_s;
    logic           crossing_s;
    logic [31:0]    load_data_s;
    logic           illegal_s;

    // FSM control
    logic           capture_s;
    logic           latch_rd0_s;
    logic           timer_clr_s;
    logic           finish_err_s;
    logic [31:0]    rsp_rdata_next_s;
    logic [31:0]    word0_s;

    // In IDLE the aligner looks at the live request so the crossing/illegal
    // decision is made in the sampling cycle; afterwards it uses the capture.
    // For loads the final read word is taken straight from mem_rdata so the
    // result can be registered on the completing edge.
    always_comb begin
        if (state_r == ST_IDLE) begin
            a_we_s    = bus.req_we;
            a_addr_s  = bus.req_addr;
            a_wdata_s = bus.req_wdata;
            a_lctrl_s = bus.req_lctrl;
            a_sctrl_s = bus.req_sctrl;
        end else begin
            a_we_s    = we_r;
            a_addr_s  = addr_r;
            a_wdata_s = wdata_r;
            a_lctrl_s = lctrl_r;
            a_sctrl_s = sctrl_r;
        end
        if (state_r == ST_ACC1) begin
            a_rd_lo_s = rd0_r;
            a_rd_hi_s = bus.mem_rdata;
        end else begin
            a_rd_lo_s = bus.mem_rdata;
            a_rd_hi_s = 32'h0000_0000;
        end
        illegal_s = is_illegal(a_we_s, a_lctrl_s, a_sctrl_s);
    end

    lsu_align u_align (
        .off       (a_addr_s[1:0]),
        .mask      (size_mask(a_we_s, a_lctrl_s, a_sctrl_s)),
        .wdata     (a_wdata_s),
        .lctrl     (a_lctrl_s),
        .rd_lo     (a_rd_lo_s),
        .rd_hi     (a_rd_hi_s),
        .be_lo     (be_lo_s),
        .be_hi     (be_hi_s),
        .wdata_lo  (wdata_lo_s),
        .wdata_hi  (wdata_hi_s),
        .crossing  (crossing_s),
        .load_data (load_data_s)
    );

    // Next-state and per-cycle control decisions
    always_comb begin
        state_next_s     = state_r;
        capture_s        = 1'b0;
        latch_rd0_s      = 1'b0;
        timer_clr_s      = 1'b0;
        finish_err_s     = 1'b0;
        rsp_rdata_next_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    capture_s = 1'b1;
                    if (illegal_s) begin
                        state_next_s = ST_DONE;
                        finish_err_s = 1'b1;
                    end else if (crossing_s && !SPLIT_EN) begin
                        state_next_s = ST_DONE;
                        finish_err_s = 1'b1;
                    end else begin
                        state_next_s = ST_ACC0;
                        timer_clr_s  = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (bus.mem_ready) begin
                    latch_rd0_s = 1'b1;
                    if (crossing_s) begin
                        state_next_s = ST_ACC1;
                        timer_clr_s  = 1'b1;
                    end else begin
                        state_next_s     = ST_DONE;
                        rsp_rdata_next_s = we_r ? 32'h0000_0000 : load_data_s;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    state_next_s = ST_DONE;
                    finish_err_s = 1'b1;
                end else begin
                    state_next_s = ST_ACC0;
                end
            end
            ST_ACC1: begin
                if (bus.mem_ready) begin
                    state_next_s     = ST_DONE;
                    rsp_rdata_next_s = we_r ? 32'h0000_0000 : load_data_s;
                end else if (timer_r == TIMER_LAST) begin
                    state_next_s = ST_DONE;
                    finish_err_s = 1'b1;
                end else begin
                    state_next_s = ST_ACC1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture, first-word read data and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            lctrl_r     <= 3'b000;
            sctrl_r     <= 2'b00;
            rd0_r       <= 32'h0000_0000;
            err_r       <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            if (capture_s) begin
                we_r    <= bus.req_we;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                lctrl_r <= bus.req_lctrl;
                sctrl_r <= bus.req_sctrl;
            end else begin
                we_r    <= we_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                lctrl_r <= lctrl_r;
                sctrl_r <= sctrl_r;
            end
            if (latch_rd0_s) begin
                rd0_r <= bus.mem_rdata;
            end else begin
                rd0_r <= rd0_r;
            end
            // Both are only non-zero during the DONE cycle
            err_r       <= finish_err_s;
            rsp_rdata_r <= rsp_rdata_next_s;
        end
    end

    // Per-transaction wait counter, cleared on entry to ACC0/ACC1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
        end else if (timer_clr_s) begin
            timer_r <= '0;
        end else if ((state_r == ST_ACC0 || state_r == ST_ACC1) && !bus.mem_ready) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Output decode: everything except stall comes from registered state,
    // so reset removes mem_req at once and the bus stays stable while waiting.
    always_comb begin
        word0_s       = {addr_r[31:2], 2'b00};
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = rsp_rdata_r;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_be    = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                bus.stall = bus.req_valid;
            end
            ST_ACC0: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_r;
                bus.mem_addr  = word0_s;
                bus.mem_wdata = wdata_lo_s;
                bus.mem_be    = be_lo_s;
            end
            ST_ACC1: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_r;
                bus.mem_addr  = word0_s + 32'd4;
                bus.mem_wdata = wdata_hi_s;
                bus.mem_be    = be_hi_s;
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_r;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

endmodule
